// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, sample points, character width
// and the majority vote used by the input filter.
package uart_pkg;

  localparam int         CHAR_W   = 8;
  localparam logic [3:0] SAMP_MID = 4'd7;
  localparam logic [3:0] SAMP_BIT = 4'd15;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Two-flop synchroniser on the raw rx pad followed by a 3-tap majority filter
// clocked by the 16x baud enable.
module uart_rx_filter
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic baud_clock,
  input  logic rx,
  output logic rx_filt
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [2:0] taps_q, taps_d;
  logic       rx_filt_q, rx_filt_d;

  // next-state for synchroniser, filter taps and the registered vote
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    if (baud_clock) begin
      taps_d = {taps_q[1:0], sync2_q};
    end else begin
      taps_d = taps_q;
    end
    rx_filt_d = maj3(taps_d);
  end

  // state registers; everything idles at the line's high level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      taps_q    <= 3'b111;
      rx_filt_q <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      taps_q    <= taps_d;
      rx_filt_q <= rx_filt_d;
    end
  end

  assign rx_filt = rx_filt_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: start-bit validation, mid-bit sampling, parity and stop-bit
// checking, and the consumer-facing byte/status registers.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter bit RX_LEGACY_MODE = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_data_ready,
  output logic       parity_err,
  output logic       overflow,
  output logic       framing_err
);

  rx_state_e         state_q, state_d;
  logic [3:0]        samp_cntr_q, samp_cntr_d;
  logic [2:0]        bit_cntr_q, bit_cntr_d;
  logic [CHAR_W-1:0] shift_q, shift_d;
  logic              armed_q, armed_d;
  logic              par_bad_q, par_bad_d;
  logic [CHAR_W-1:0] rx_byte_q, rx_byte_d;
  logic              ready_q, ready_d;
  logic              parity_err_q, parity_err_d;
  logic              overflow_q, overflow_d;
  logic              framing_err_q, framing_err_d;

  logic              rx_filt_s;
  logic              samp_bit_s;
  logic [2:0]        last_bit_s;
  logic [CHAR_W-1:0] data_bits_s;
  logic              stop_ok_s;
  logic              start_entry_s;

  uart_rx_filter u_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_clock (baud_clock),
    .rx         (rx),
    .rx_filt    (rx_filt_s)
  );

  // 7-bit characters sit in shift_q[7:1] because bits are shifted in MSB-down
  assign samp_bit_s  = baud_clock && (samp_cntr_q == SAMP_BIT);
  assign last_bit_s  = bit8 ? 3'd7 : 3'd6;
  assign data_bits_s = bit8 ? shift_q : {1'b0, shift_q[7:1]};

  // frame FSM: next state, sample counters and shift register
  always_comb begin
    state_d       = state_q;
    bit_cntr_d    = bit_cntr_q;
    shift_d       = shift_q;
    armed_d       = armed_q;
    par_bad_d     = par_bad_q;
    framing_err_d = 1'b0;
    stop_ok_s     = 1'b0;
    start_entry_s = 1'b0;
    if (baud_clock) begin
      samp_cntr_d = samp_cntr_q + 4'd1;
    end else begin
      samp_cntr_d = samp_cntr_q;
    end

    case (state_q)
      RX_IDLE: begin
        samp_cntr_d = 4'd0;
        if (rx_filt_s) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
        if (baud_clock && armed_q && !rx_filt_s) begin
          state_d       = RX_START;
          bit_cntr_d    = 3'd0;
          shift_d       = '0;
          par_bad_d     = 1'b0;
          start_entry_s = 1'b1;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (baud_clock && (samp_cntr_q == SAMP_MID)) begin
          samp_cntr_d = 4'd0;
          if (!rx_filt_s) begin
            state_d = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (samp_bit_s) begin
          shift_d = {rx_filt_s, shift_q[CHAR_W-1:1]};
          // >= keeps the FSM moving if bit8 drops mid-frame past bit 6
          if (bit_cntr_q >= last_bit_s) begin
            bit_cntr_d = 3'd0;
            state_d    = parity_en ? RX_PARITY : RX_STOP;
          end else begin
            bit_cntr_d = bit_cntr_q + 3'd1;
          end
        end else begin
          state_d = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (samp_bit_s) begin
          par_bad_d = ((^data_bits_s) ^ rx_filt_s) != odd_n_even;
          state_d   = RX_STOP;
        end else begin
          state_d = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (samp_bit_s) begin
          state_d = RX_IDLE;
          if (rx_filt_s) begin
            stop_ok_s = 1'b1;
          end else begin
            framing_err_d = 1'b1;
            armed_d       = 1'b0;
          end
        end else begin
          state_d = RX_STOP;
        end
      end
      default: begin
        state_d     = RX_IDLE;
        samp_cntr_d = 4'd0;
        bit_cntr_d  = 3'd0;
      end
    endcase
  end

  // consumer-facing byte and status flags
  always_comb begin
    rx_byte_d    = rx_byte_q;
    ready_d      = ready_q;
    overflow_d   = overflow_q;
    parity_err_d = parity_err_q;
    if (stop_ok_s) begin
      rx_byte_d  = data_bits_s;
      ready_d    = 1'b1;
      overflow_d = ready_q && !read_rx_byte;
      if (RX_LEGACY_MODE && !read_rx_byte) begin
        parity_err_d = parity_err_q | par_bad_q;
      end else begin
        parity_err_d = par_bad_q;
      end
    end else begin
      if (read_rx_byte) begin
        ready_d    = 1'b0;
        overflow_d = 1'b0;
      end else begin
        ready_d    = ready_q;
        overflow_d = overflow_q;
      end
      if ((read_rx_byte && RX_LEGACY_MODE) || (start_entry_s && !RX_LEGACY_MODE)) begin
        parity_err_d = 1'b0;
      end else begin
        parity_err_d = parity_err_q;
      end
    end
  end

  // all state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RX_IDLE;
      samp_cntr_q   <= 4'd0;
      bit_cntr_q    <= 3'd0;
      shift_q       <= '0;
      armed_q       <= 1'b0;
      par_bad_q     <= 1'b0;
      rx_byte_q     <= '0;
      ready_q       <= 1'b0;
      parity_err_q  <= 1'b0;
      overflow_q    <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      samp_cntr_q   <= samp_cntr_d;
      bit_cntr_q    <= bit_cntr_d;
      shift_q       <= shift_d;
      armed_q       <= armed_d;
      par_bad_q     <= par_bad_d;
      rx_byte_q     <= rx_byte_d;
      ready_q       <= ready_d;
      parity_err_q  <= parity_err_d;
      overflow_q    <= overflow_d;
      framing_err_q <= framing_err_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_data_ready = ready_q;
  assign parity_err    = parity_err_q;
  assign overflow      = overflow_q;
  assign framing_err   = framing_err_q;

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Receive-side companion to the UART baud generator. Consumes the 16x `baud_clock` tick and deserialises the asynchronous `rx` line into bytes, with start-bit validation, mid-bit sampling, majority filtering, parity and stop-bit checking. Sits between the pad and the RX FIFO or APB register file, clocked entirely on the system clock; `baud_clock` acts only as an enable.

## Interface
- `RX_LEGACY_MODE`, 0: when 1, `parity_err` is held until read instead of being cleared on the next start bit.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `baud_clock`  in  1  one-`clk` enable pulse at 16x the baud rate.
- `rx`  in  1  serial line, asynchronous, idles high.
- `bit8`  in  1  1 selects 8 data bits, 0 selects 7.
- `parity_en`  in  1  expect a parity bit after the data bits.
- `odd_n_even`  in  1  1 selects odd parity, 0 selects even.
- `read_rx_byte`  in  1  one-`clk` pulse; consumer has taken `rx_byte`.
- `rx_byte`  out  8  last received character, LSB is the first bit received; bit 7 is 0 in 7-bit mode.
- `rx_data_ready`  out  1  a new character is valid.
- `parity_err`  out  1  parity mismatch on the last character.
- `overflow`  out  1  a character completed while `rx_data_ready` was still 1.
- `framing_err`  out  1  one-`clk` pulse when the stop bit is sampled low.
- All outputs reset to 0.

## Operation
- **Input conditioning**
  - `rx` passes through a 2-flop synchroniser; synchroniser flops reset to 1.
  - On each `baud_clock`, the synchronised value shifts into a 3-bit filter register (reset 3'b111).
  - `rx_filt` is the majority of the 3 filter bits.
- **State machine:** IDLE, START, DATA, PARITY, STOP.
  - A 4-bit `samp_cntr` advances only on `baud_clock`.
  - A 3-bit `bit_cntr` counts data bits.
- **IDLE**
  - An `armed` flag sets when `rx_filt`=1.
  - On a `baud_clock` with `armed`=1 and `rx_filt`=0, go to START with `samp_cntr`=0.
- **START**
  - At the `baud_clock` where `samp_cntr`=7 (mid start bit):
    - `rx_filt`=0: go to DATA, `samp_cntr`←0.
    - `rx_filt`=1: glitch; return to IDLE.
- **DATA**
  - At each `baud_clock` with `samp_cntr`=15, shift `rx_filt` into the shift register MSB-down.
  - After the 8th bit (`bit8`=1) or 7th bit (`bit8`=0), go to PARITY if `parity_en`, else STOP.
- **PARITY**
  - Sample at `samp_cntr`=15.
  - Error if the XOR of the data bits and the parity bit is not 1 for odd parity or not 0 for even parity.
- **STOP:** sample at `samp_cntr`=15.
  - **Stop bit = 1**
    - Load `rx_byte` (right-justified; bit 7 forced to 0 in 7-bit mode).
    - Set `rx_data_ready`.
    - Set `overflow` if `rx_data_ready` was already 1.
    - Update `parity_err`.
  - **Stop bit = 0**
    - Pulse `framing_err`.
    - Do not load `rx_byte`.
    - Clear `armed`, so a break or stuck-low line never retriggers until `rx` returns high.
  - Return to IDLE in both cases.
- **Read and overwrite rules**
  - `read_rx_byte` clears `rx_data_ready` and `overflow`.
  - It also clears `parity_err` when `RX_LEGACY_MODE`=1.
  - When `RX_LEGACY_MODE`=0, `parity_err` is cleared at the next START entry.
  - A byte completing in the same cycle as `read_rx_byte` leaves `rx_data_ready`=1 and does not set `overflow`.
  - On overflow the new byte overwrites `rx_byte`.
- **Configuration changes:** `bit8`, `parity_en` and `odd_n_even` are sampled live. Software changes them only while idle; mid-frame changes are undefined but must not hang the FSM.
- **Reset mid-frame:** the FSM returns to IDLE, outputs go to 0, `armed`=0.

## Timing
- Synchroniser plus filter delays edge detection by 2 `clk` plus 1–2 `baud_clock` ticks.
- Nominal start detect to first data sample: 8+16 ticks. Bit n is sampled 16 ticks after bit n−1.
- `rx_data_ready`, `rx_byte` and `parity_err` update on the `clk` edge following the stop-bit sample tick, registered in one cycle.
- `framing_err` is high for exactly one `clk`.
- No `baud_clock` means no state change. Behaviour is identical whether `baud_clock` is high every cycle (baud_val=0) or sparse.

## Structure
- Shared package `uart_pkg` holds:
  - the RX state enum (IDLE/START/DATA/PARITY/STOP);
  - `SAMP_MID`=7 and `SAMP_BIT`=15;
  - the 8-bit character width.
- One sub-module, `uart_rx_filter`, holds the synchroniser plus the 3-tap majority filter (inputs `clk`, `reset_n`, `baud_clock`, `rx`; output `rx_filt`).
- The FSM, counters and registers stay in the top.

## Test plan
- 8N1, `baud_clock` every 4 clk, send 0xA5 → `rx_byte`=0xA5, `rx_data_ready`=1, no errors; `read_rx_byte` clears ready.
- 7-bit, even parity, send 0x41 with parity bit 0 → `rx_byte`=0x41, `parity_err`=0; repeat with parity bit 1 → `parity_err`=1.
- Start-bit glitch 5 ticks low, then high → FSM back to IDLE, no `rx_data_ready`, no `framing_err`.
- Send 0x55 with stop bit 0, hold line low 40 bit-times → one `framing_err` pulse, no retrigger until `rx` goes high, then 0x33 is received correctly.
- Two bytes 0x12, 0x34 without read → `overflow`=1, `rx_byte`=0x34; second case: `read_rx_byte` coincident with completion → `overflow`=0, ready=1.
- Assert `reset_n` mid-DATA → all outputs 0; the next full frame 0xC3 is received correctly.
